hazard_detection_id: RTL
========================

// Module: hazard_detection_ID
// PURPOSE
// - ID-stage stall/flush unit; the issue-side counterpart of the EXE-stage forwarding selector.
// - Keeps a 3-deep shadow of in-flight writers (EXE, MEM, WB) fed from what ID actually issues.
// - Stalls ID when a source cannot be supplied in time, either by forwarding or by the register file.
// - Flushes IF/ID on a taken branch.
// - Counts stall cycles for performance monitoring.
// PARAMETERS
// - REG_ADDR_LEN  5   register-file address width
// - STALL_CNT_W   16  width of the saturating stall counter
// PORTS
// - clk             in   1             rising-edge clock
// - rst             in   1             synchronous, active-high reset
// - valid_ID        in   1             ID holds a real instruction
// - src1_ID         in   REG_ADDR_LEN  first source register
// - src2_ID         in   REG_ADDR_LEN  second source register
// - two_src_ID      in   1             instruction reads src2 (R-type, store, bne/beq)
// - dest_ID         in   REG_ADDR_LEN  destination register of the ID instruction
// - WB_EN_ID        in   1             ID instruction writes back
// - MEM_R_EN_ID     in   1             ID instruction is a load
// - branch_taken    in   1             branch resolved taken in EXE this cycle
// - hazard_detected out  1             freeze PC and IF/ID; insert bubble into ID/EXE
// - flush_IF_ID     out  1             kill the IF/ID contents
// - stall_count     out  STALL_CNT_W   saturating count of stall cycles
// BEHAVIOUR
// Shadow slots and advance
// - Slots EXE, MEM and WB each hold {v, dest, wb_en, mem_r_en}.
// - Every clk: WB<=MEM, MEM<=EXE, EXE<=issue ? {1, dest_ID, WB_EN_ID, MEM_R_EN_ID} : bubble.
// - issue = valid_ID & ~hazard_detected & ~branch_taken. A bubble has all fields 0.
// Source matching
// - hit(S,r) = S.v & S.wb_en & (S.dest==r) & (r!=0). Writes to R0 never create a hazard.
// - need(S) = hit(S,src1_ID) | (two_src_ID & hit(S,src2_ID)).
// Stall rule (combinational, same cycle as the ID inputs; see CONFIGURATION for the two variants)
// - hazard_detected = valid_ID & ~branch_taken & <stall rule>.
// Flush
// - flush_IF_ID = branch_taken, combinational.
// - branch_taken wins over any hazard: hazard_detected=0 that cycle and the EXE slot receives a bubble.
// Stall counter
// - stall_count += 1 on every clk where hazard_detected=1.
// - Saturates at all-ones and never wraps.
// Reset
// - All slots cleared to bubble; stall_count=0.
// - hazard_detected=0 from the first post-reset cycle; flush_IF_ID follows branch_taken.
// - rst asserted mid-stall: slots are cleared on that edge and the stall ends the next cycle.
// Boundaries
// - valid_ID=0: no stall, bubble issued.
// - Back-to-back dependent instructions re-evaluate every cycle as the producer advances through the slots.
// CONFIGURATION
// Macro HAZARD_FORWARD_EN (forwarding present downstream)
// - Defined: stall rule = EXE.mem_r_en & need(EXE).
// - Only load-use stalls, for exactly 1 cycle; ALU producers never stall.
// Macro not defined (no forwarding)
// - Stall rule = need(EXE) | need(MEM) | need(WB).
// - The consumer waits until the producer has left WB, up to 3 cycles.
// - A load is handled like any other writer.
// TESTING
// - FWD_EN: lw r2 then add r3,r2,r4 -> hazard_detected=1 for 1 cycle, add issues next cycle, stall_count=1.
// - FWD_EN: add r1 then sub r5,r1,r1 -> no stall, stall_count stays 0.
// - No macro: add r1 then add r3,r1,r2 -> hazard_detected=1 for 3 consecutive cycles, then issue; stall_count=3.
// - Writer with dest=0, or lw r7 followed by addi (two_src_ID=0) whose src2 field is 7 -> no stall in either config.
// - Load-use hazard coincident with branch_taken=1 -> hazard_detected=0, flush_IF_ID=1, EXE slot bubble next cycle.
// - rst pulse during a 3-cycle stall -> hazard_detected=0 and stall_count=0 next cycle.
// - STALL_CNT_W=2 with 5 stall cycles -> stall_count=3 (saturated).

Source files
------------

// File: rtl/hazard_detection_id.sv
// ID-stage stall/flush unit with a 3-deep shadow of in-flight writers and a saturating stall counter.
// Define HAZARD_FORWARD_EN when EXE forwarding exists: only load-use stalls remain.
module hazard_detection_id #(
  parameter int REG_ADDR_LEN = 5,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_ID,
  input  logic [REG_ADDR_LEN-1:0] src1_ID,
  input  logic [REG_ADDR_LEN-1:0] src2_ID,
  input  logic                    two_src_ID,
  input  logic [REG_ADDR_LEN-1:0] dest_ID,
  input  logic                    WB_EN_ID,
  input  logic                    MEM_R_EN_ID,
  input  logic                    branch_taken,
  output logic                    hazard_detected,
  output logic                    flush_IF_ID,
  output logic [STALL_CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic                    v;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    wb_en;
    logic                    mem_r_en;
  } slot_t;

  slot_t exe_q, mem_q, wb_q;
  slot_t exe_d, mem_d, wb_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
  logic stall_rule;
  logic issue;
  logic unused_wb;

  function automatic logic hit(input slot_t s, input logic [REG_ADDR_LEN-1:0] r);
    return s.v & s.wb_en & (s.dest == r) & (r != '0);
  endfunction

  function automatic logic need(input slot_t s, input logic [REG_ADDR_LEN-1:0] r1,
                                input logic [REG_ADDR_LEN-1:0] r2, input logic two);
    return hit(s, r1) | (two & hit(s, r2));
  endfunction

  always_comb begin
`ifdef HAZARD_FORWARD_EN
    stall_rule = exe_q.mem_r_en & need(exe_q, src1_ID, src2_ID, two_src_ID);
`else
    stall_rule = need(exe_q, src1_ID, src2_ID, two_src_ID)
               | need(mem_q, src1_ID, src2_ID, two_src_ID)
               | need(wb_q,  src1_ID, src2_ID, two_src_ID);
`endif
    // A taken branch overrides any stall and kills the ID instruction.
    hazard_detected = valid_ID & ~branch_taken & stall_rule;
    flush_IF_ID     = branch_taken;
    issue           = valid_ID & ~hazard_detected & ~branch_taken;

    exe_d = '0;
    if (issue) begin
      exe_d.v        = 1'b1;
      exe_d.dest     = dest_ID;
      exe_d.wb_en    = WB_EN_ID;
      exe_d.mem_r_en = MEM_R_EN_ID;
    end
    mem_d = exe_q;
    wb_d  = mem_q;

    stall_count_d = stall_count_q;
    if (hazard_detected && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q         <= '0;
      mem_q         <= '0;
      wb_q          <= '0;
      stall_count_q <= '0;
    end else begin
      exe_q         <= exe_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  // The WB load flag is carried only so every slot has the same shape.
  assign unused_wb   = ^wb_q;
  assign stall_count = stall_count_q;

endmodule
